// File: rtl/wb_pkg.sv
// Shared definitions for the MEM->WB write port.
// Write bus layout (43 bits): {en, aim[1:0], rd[4:0], sel[2:0], w_data[31:0]}
// aim selects the destination: 00 GPR, 01 LO, 10 HI, 11 CP0.
package wb_pkg;

  localparam int WB_BUS_W = 43;
  localparam int EN_B     = 42;
  localparam int AIM_MSB  = 41;
  localparam int AIM_LSB  = 40;
  localparam int RD_LSB   = 35;
  localparam int SEL_LSB  = 32;

  localparam logic [1:0] AIM_REG = 2'b00;
  localparam logic [1:0] AIM_LO  = 2'b01;
  localparam logic [1:0] AIM_HI  = 2'b10;
  localparam logic [1:0] AIM_CP0 = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_HI = 2'd1,
    PEND_LO = 2'd2
  } arb_state_e;

  function automatic logic [WB_BUS_W-1:0] wb_pack(
    input logic        en,
    input logic [1:0]  aim,
    input logic [4:0]  rd,
    input logic [2:0]  sel,
    input logic [31:0] data
  );
    return {en, aim, rd, sel, data};
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the MEM stage / mul-div unit and the WB port arbiter.
//   mem_wb_bus  pipeline write request from MEM (bit 42 = en)
//   md_valid    mul/div result available, held until accepted
//   md_hi/md_lo result pair destined for HI and LO
//   md_ready    arbiter accepts the pair this cycle
//   wb_bus      granted write towards WB
//   pipe_stall  MEM must hold mem_wb_bus this cycle
//   hilo_busy   buffered HI/LO write still pending
// master: the producer side (MEM stage + mul/div); slave: the arbiter.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic [WB_BUS_W-1:0] mem_wb_bus;
  logic                md_valid;
  logic [31:0]         md_hi;
  logic [31:0]         md_lo;
  logic                md_ready;
  logic [WB_BUS_W-1:0] wb_bus;
  logic                pipe_stall;
  logic                hilo_busy;

  modport master (
    output mem_wb_bus, md_valid, md_hi, md_lo,
    input  md_ready, wb_bus, pipe_stall, hilo_busy
  );

  modport slave (
    input  mem_wb_bus, md_valid, md_hi, md_lo,
    output md_ready, wb_bus, pipe_stall, hilo_busy
  );

endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single MEM->WB write port between the in-order pipeline and
// the multi-cycle mul/div unit. A result pair is captured in IDLE and later
// drained as two writes, HI then LO, using idle pipeline slots. The buffer
// takes the port from a valid pipeline write on an HI/LO ordering hazard or
// after STARVE_LIMIT consecutive blocked cycles; the pipeline write is then
// held via pipe_stall.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; forces all outputs low while high
//   port  wb_port_arbiter_if.slave (see interface header)
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter  int STARVE_LIMIT = 4,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   port
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic       pipe_en;
  logic [1:0] pipe_aim;
  logic       hazard;
  logic       drain;

  assign pipe_en  = port.mem_wb_bus[EN_B];
  assign pipe_aim = port.mem_wb_bus[AIM_MSB:AIM_LSB];

  // mthi/mtlo must not overtake an older buffered mul/div result.
  assign hazard = pipe_en && ((pipe_aim == AIM_LO) || (pipe_aim == AIM_HI));

  // Only meaningful in the pending states; gated by state below.
  assign drain = !pipe_en || hazard || (starve_cnt == CNT_MAX);

  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt;
    hi_d            = hi_q;
    lo_d            = lo_q;
    port.wb_bus     = port.mem_wb_bus;
    port.pipe_stall = 1'b0;
    port.md_ready   = 1'b0;
    port.hilo_busy  = 1'b0;

    case (state_q)
      IDLE: begin
        port.md_ready = 1'b1;
        starve_cnt_d  = '0;
        // The pair is only captured here; it is never written this cycle.
        if (port.md_valid) begin
          hi_d    = port.md_hi;
          lo_d    = port.md_lo;
          state_d = PEND_HI;
        end
      end
      PEND_HI, PEND_LO: begin
        port.hilo_busy = 1'b1;
        if (drain) begin
          if (state_q == PEND_HI) begin
            port.wb_bus = wb_pack(1'b1, AIM_HI, 5'd0, 3'd0, hi_q);
            state_d     = PEND_LO;
          end else begin
            port.wb_bus = wb_pack(1'b1, AIM_LO, 5'd0, 3'd0, lo_q);
            state_d     = IDLE;
          end
          // A valid pipeline write loses the port and must be held, not dropped.
          port.pipe_stall = pipe_en;
          starve_cnt_d    = '0;
        end else if (starve_cnt != CNT_MAX) begin
          starve_cnt_d = starve_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      port.wb_bus     = '0;
      port.pipe_stall = 1'b0;
      port.md_ready   = 1'b0;
      port.hilo_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_cnt <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, idle drain, starvation,
// ordering hazard, mid-operation reset and back-to-back results.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if ifc ();

  wb_port_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .port (ifc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic v, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [42:0] b);
    ifc.md_valid   = v;
    ifc.md_hi      = hi;
    ifc.md_lo      = lo;
    ifc.mem_wb_bus = b;
  endtask

  function automatic logic [42:0] hi_wr(input logic [31:0] d);
    return {1'b1, 2'b10, 5'd0, 3'd0, d};
  endfunction

  function automatic logic [42:0] lo_wr(input logic [31:0] d);
    return {1'b1, 2'b01, 5'd0, 3'd0, d};
  endfunction

  function automatic logic [42:0] gpr_wr(input int i);
    return {1'b1, 2'b00, 5'd5, 3'd0, 32'hC000_0000 + 32'(i)};
  endfunction

  task automatic chk_out(input string tag, input logic [42:0] wb, input logic stall,
                         input logic ready, input logic busy);
    chk({tag, ".wb"},    64'(ifc.wb_bus),     64'(wb));
    chk({tag, ".stall"}, 64'(ifc.pipe_stall), 64'(stall));
    chk({tag, ".ready"}, 64'(ifc.md_ready),   64'(ready));
    chk({tag, ".busy"},  64'(ifc.hilo_busy),  64'(busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [42:0] mthi;
    logic [42:0] cp0;
    int          idx;
    logic        drn;

    mthi = {1'b1, 2'b10, 5'd0, 3'd0, 32'h0000_1234};
    cp0  = {1'b1, 2'b11, 5'd12, 3'd0, 32'h0000_CAFE};

    // 1: reset held two cycles with live inputs
    rst = 1'b1;
    drive(1'b1, 32'hDEAD_0001, 32'hDEAD_0002, gpr_wr(99));
    tick(); settle();
    chk_out("rst0", 43'd0, 1'b0, 1'b0, 1'b0);
    tick(); settle();
    chk_out("rst1", 43'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 43'd0);
    settle();
    chk_out("rst_rel", 43'd0, 1'b0, 1'b1, 1'b0);

    // 2: idle drain
    tick(); drive(1'b1, 32'hAAAA_0001, 32'h5555_0002, 43'd0); settle();
    chk_out("idle.c0", 43'd0, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b0, 32'd0, 32'd0, 43'd0); settle();
    chk_out("idle.c1", hi_wr(32'hAAAA_0001), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("idle.c2", lo_wr(32'h5555_0002), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("idle.c3", 43'd0, 1'b0, 1'b1, 1'b0);

    // 3: starvation under continuous GPR writes; stalled writes are re-presented
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      drive(c == 0, 32'h1111_0003, 32'h2222_0004, gpr_wr(idx));
      settle();
      drn = (c == 5) || (c == 10);
      if (c == 5)
        chk("starve.hi", 64'(ifc.wb_bus), 64'(hi_wr(32'h1111_0003)));
      else if (c == 10)
        chk("starve.lo", 64'(ifc.wb_bus), 64'(lo_wr(32'h2222_0004)));
      else
        chk($sformatf("starve.pass%0d", c), 64'(ifc.wb_bus), 64'(gpr_wr(idx)));
      chk($sformatf("starve.stall%0d", c), 64'(ifc.pipe_stall), 64'(drn));
      if (!drn) idx++;
    end
    chk("starve.busy_end", 64'(ifc.hilo_busy), 64'd0);
    chk("starve.count", 64'(idx), 64'd10);

    // 4: mthi while HI pending
    tick(); drive(1'b1, 32'h3333_0005, 32'h4444_0006, 43'd0); settle();
    chk_out("ord.c0", 43'd0, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b0, 32'd0, 32'd0, mthi); settle();
    chk_out("ord.c1", hi_wr(32'h3333_0005), 1'b1, 1'b0, 1'b1);
    tick(); settle();
    chk_out("ord.c2", lo_wr(32'h4444_0006), 1'b1, 1'b0, 1'b1);
    tick(); settle();
    chk_out("ord.c3", mthi, 1'b0, 1'b1, 1'b0);

    // 5: CP0 write does not preempt; reset while LO pending
    tick(); drive(1'b1, 32'h5555_0007, 32'h6666_0008, 43'd0); settle();
    tick(); drive(1'b0, 32'd0, 32'd0, cp0); settle();
    chk_out("mrst.cp0", cp0, 1'b0, 1'b0, 1'b1);
    tick(); drive(1'b0, 32'd0, 32'd0, 43'd0); settle();
    chk_out("mrst.hi", hi_wr(32'h5555_0007), 1'b0, 1'b0, 1'b1);
    tick(); rst = 1'b1; settle();
    chk_out("mrst.rst", 43'd0, 1'b0, 1'b0, 1'b0);
    tick(); rst = 1'b0; settle();
    chk_out("mrst.after", 43'd0, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 32'h7777_0009, 32'h8888_000A, 43'd0); settle();
    tick(); drive(1'b0, 32'd0, 32'd0, 43'd0); settle();
    chk_out("mrst.n_hi", hi_wr(32'h7777_0009), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("mrst.n_lo", lo_wr(32'h8888_000A), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("mrst.n_end", 43'd0, 1'b0, 1'b1, 1'b0);

    // 6: back-to-back pairs with md_valid held high
    tick(); drive(1'b1, 32'h9999_000B, 32'hAAAA_000C, 43'd0); settle();
    chk("b2b.acc_a", 64'(ifc.md_ready), 64'd1);
    tick(); drive(1'b1, 32'hBBBB_000D, 32'hCCCC_000E, 43'd0); settle();
    chk_out("b2b.hi_a", hi_wr(32'h9999_000B), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("b2b.lo_a", lo_wr(32'hAAAA_000C), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("b2b.acc_b", 43'd0, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b0, 32'd0, 32'd0, 43'd0); settle();
    chk_out("b2b.hi_b", hi_wr(32'hBBBB_000D), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("b2b.lo_b", lo_wr(32'hCCCC_000E), 1'b0, 1'b0, 1'b1);
    tick(); settle();
    chk_out("b2b.end", 43'd0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
